// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, the signed audio word type and a
// width-generic saturating clip used by the audio output stage.
//   IN_W  demodulated input sample width (unsigned)
//   AW    internal signed audio word width
//   MID   mid-scale code of the unsigned modulator input, 2^(AW-1)
package audio_pkg;

   localparam int unsigned IN_W = 8;
   localparam int unsigned AW   = 12;
   localparam int unsigned MID  = 2 ** (AW - 1);

   typedef logic signed [AW-1:0] audio_t;

   // Clip v to the signed range of a w-bit word; ovf reports that clipping happened.
   function automatic logic signed [31:0] sat_clip(input  logic signed [31:0] v,
                                                   input  int unsigned        w,
                                                   output logic               ovf);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      logic signed [31:0] r;
      hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo  = -(32'sd1 <<< (w - 1));
      r   = v;
      ovf = 1'b0;
      if (v > hi) begin
         r   = hi;
         ovf = 1'b1;
      end else if (v < lo) begin
         r   = lo;
         ovf = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sd_mod1.sv
// sd_mod1: first-order sigma-delta modulator producing a 1-bit PDM stream.
// Ones density equals u / 2^AW exactly over any 2^AW-cycle window.
// Ports:
//   clk, rst_n  clock (also the PDM bit clock), async active-low reset
//   u           unsigned modulator input, AW bits
//   pdm_out     registered bitstream (carry out of the accumulator)
module sd_mod1 #(
   parameter int unsigned AW = audio_pkg::AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] u,
   output logic          pdm_out
);

   // Only the low AW bits carry state; the top bit of the sum is the output bit.
   logic [AW-1:0] acc;
   logic [AW:0]   acc_next;

   always_comb begin
      acc_next = {1'b0, acc} + {1'b0, u};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         pdm_out <= 1'b0;
      end else begin
         acc     <= acc_next[AW-1:0];
         pdm_out <= acc_next[AW];
      end
   end

endmodule

// File: rtl/audio_pdm_out.sv
// audio_pdm_out: AM demodulator audio back end. Removes the DC component
// of the unsigned envelope samples, applies a power-of-two gain with
// saturation, holds the last sample and drives a 1-bit PDM stream.
// Build option: define AUDIO_DC_BLOCK_EN to build the adaptive DC tracker;
// otherwise dc is the constant 2^(IN_W-1).
// Ports:
//   clk, rst_n  single clock, async active-low reset
//   d_in        unsigned envelope sample, qualified by d_valid strobe
//   gain        left shift 0..7 applied after DC removal
//   mute        forces mid-scale at the modulator input while high
//   pdm_out     registered sigma-delta bitstream
//   sat         one-cycle pulse when the gain stage clipped
//   underrun    high while no sample has arrived for TIMEOUT cycles
module audio_pdm_out #(
   parameter int unsigned IN_W     = audio_pkg::IN_W,
   parameter int unsigned AW       = audio_pkg::AW,
   parameter int unsigned DC_SHIFT = 8,
   parameter int unsigned TIMEOUT  = 65535
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IN_W-1:0] d_in,
   input  logic            d_valid,
   input  logic [2:0]      gain,
   input  logic            mute,
   output logic            pdm_out,
   output logic            sat,
   output logic            underrun
);
   import audio_pkg::*;

   localparam int unsigned GW = IN_W + 8;
   localparam int unsigned DW = IN_W + DC_SHIFT;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [DW-1:0] DC_ACC_RST = DW'(2 ** (IN_W - 1)) << DC_SHIFT;
   localparam logic [AW-1:0] MID_U      = AW'(2 ** (AW - 1));

   logic [IN_W-1:0]        x;
   logic                   v1;
   logic signed [IN_W:0]   y;
   logic                   v2;
   logic [IN_W-1:0]        dc;
   logic signed [GW-1:0]   g;
   logic signed [AW-1:0]   hold_next;
   logic                   clip_ovf;
   logic signed [AW-1:0]   s_hold;
   logic [AW-1:0]          u;
   logic [CW-1:0]          wd_cnt;
   logic [CW-1:0]          wd_next;

   // S1: capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x  <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= d_valid;
         if (d_valid) x <= d_in;
      end
   end

`ifdef AUDIO_DC_BLOCK_EN
   // Leaky DC tracker; the update adds x and removes dc, so it stays bounded.
   logic [DW-1:0] dc_acc;

   always_comb begin
      dc = IN_W'(dc_acc >> DC_SHIFT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dc_acc <= DC_ACC_RST;
      end else if (v1) begin
         dc_acc <= dc_acc + DW'(x) - DW'(dc);
      end
   end
`else
   // Fixed mid-code offset: same value the tracker starts from.
   always_comb begin
      dc = IN_W'(DC_ACC_RST >> DC_SHIFT);
   end
`endif

   // S2: DC removal
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y  <= '0;
         v2 <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) y <= $signed({1'b0, x}) - $signed({1'b0, dc});
      end
   end

   // S3: gain at full width, then clip to the audio word
   always_comb begin
      clip_ovf  = 1'b0;
      g         = GW'(y) <<< gain;
      hold_next = AW'(sat_clip(32'(g), AW, clip_ovf));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_hold <= '0;
         sat    <= 1'b0;
      end else begin
         sat <= v2 & clip_ovf;
         if (v2) s_hold <= hold_next;
      end
   end

   // Offset-binary modulator input; mute and underrun only force u, s_hold is kept.
   always_comb begin
      u = {~s_hold[AW-1], s_hold[AW-2:0]};
      if (mute || underrun) u = MID_U;
   end

   sd_mod1 #(.AW(AW)) u_mod (
      .clk     (clk),
      .rst_n   (rst_n),
      .u       (u),
      .pdm_out (pdm_out)
   );

   // Watchdog: cycles since the last strobe, saturating at TIMEOUT
   always_comb begin
      wd_next = wd_cnt;
      if (d_valid)                        wd_next = '0;
      else if (wd_cnt != CW'(TIMEOUT))    wd_next = wd_cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt   <= CW'(TIMEOUT);
         underrun <= 1'b1;
      end else begin
         wd_cnt   <= wd_next;
         underrun <= (wd_next == CW'(TIMEOUT));
      end
   end

endmodule

// File: doc/audio_pdm_out.md
# audio_pdm_out

Audio output stage that sits directly downstream of the AM demodulator. It takes the 8-bit unsigned envelope samples the demodulator produces and removes their DC component. It applies a selectable power-of-two gain with saturation, then drives a 1-bit first-order sigma-delta (PDM) stream to an external RC-filtered audio pin. It also holds the last sample between input strobes, mutes on request and flags input underrun.

## Interface
- Reset: asynchronous, active-low (`rst_n`); clock is `clk`, single clock domain.
- `IN_W`, default 8: width of the demodulated input sample, unsigned.
- `AW`, default 12: width of the internal signed audio word.
- `DC_SHIFT`, default 8: DC tracker time constant, 2^-DC_SHIFT per sample.
- `TIMEOUT`, default 65535: `clk` cycles without `d_valid` before underrun is declared.
- `clk` input, 1 bit: system clock, also the PDM bit clock.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `d_in` input, IN_W bits: demodulated envelope sample, unsigned.
- `d_valid` input, 1 bit: one-cycle strobe marking `d_in` valid; allowed on back-to-back cycles.
- `gain` input, 3 bits: left shift 0..7 applied after DC removal.
- `mute` input, 1 bit: forces the output to mid-scale while high.
- `pdm_out` output, 1 bit: sigma-delta bitstream, registered.
- `sat` output, 1 bit: one-cycle pulse when the gain stage clipped.
- `underrun` output, 1 bit: high while no sample has arrived for TIMEOUT cycles.

## Operation
- **S1, capture:** on `d_valid`, `x <= d_in`. A valid flag advances with the data through each stage.
- **S2, DC removal:** `y = x - dc`, signed, IN_W+1 bits.
  - `dc = dc_acc >> DC_SHIFT`.
  - On each valid: `dc_acc <= dc_acc + x - dc`.
  - `dc_acc` is IN_W+DC_SHIFT bits, unsigned, and never wraps because the update is bounded.
- **S3, gain:** `g = y <<< gain`, computed at full width (IN_W+8 bits).
  - Clip `g` to [-2^(AW-1), 2^(AW-1)-1].
  - If clipping occurred, pulse `sat` for one cycle.
  - `s_hold <= clipped g`. `s_hold` persists until the next valid sample.
- **Modulator:** runs every `clk`, independent of `d_valid`.
  - `u = s_hold + 2^(AW-1)`, unsigned AW bits; `u = 2^(AW-1)` instead when muted or in underrun.
  - `acc` is AW+1 bits: `acc <= {1'b0, acc[AW-1:0]} + u`.
  - `pdm_out <= acc_next[AW]`.
  - Ones density equals u / 2^AW exactly over any 2^AW-cycle window.
- **Watchdog:** counter is cleared on `d_valid` and otherwise increments, saturating at TIMEOUT.
  - `underrun = (count == TIMEOUT)`.
  - The first `d_valid` clears `underrun` on the next edge.
  - `s_hold` is not overwritten during underrun; only `u` is forced.
- **Simultaneous events:**
  - `mute` and underrun both force mid-scale.
  - A `d_valid` during `mute` still updates the DC tracker and `s_hold`.
- **Reset values:**
  - `pdm_out`=0, `sat`=0, `underrun`=1.
  - `acc`=0, `s_hold`=0, watchdog count=TIMEOUT.
  - `dc_acc` = 2^(IN_W-1) << DC_SHIFT, i.e. dc=128.
  - All pipeline valids cleared.
- **Reset mid-operation:** in-flight samples are discarded; behaviour restarts exactly as from power-up.

## Timing
- `d_valid` sampled at edge N: `x` loads at N, `y` registers at N+1, `s_hold`/`sat` update at N+2.
  - `pdm_out` at edge N+3 is the first bit computed from the new `u`.
- `gain`, `mute`: sampled every cycle, no synchronisation; the caller keeps them static or quasi-static.
- Throughput: one sample per cycle maximum.
- Watchdog: `underrun` asserts at edge TIMEOUT after the last `d_valid`.

## Configuration
- `AUDIO_DC_BLOCK_EN` defined: the DC tracker is built as described above.
- Undefined: `dc` is the constant 2^(IN_W-1), no `dc_acc` register exists, and `y = x - 128`.
- All other behaviour is identical in both builds.

## Structure
- Package `audio_pkg` holds:
  - constants AW, IN_W, MID = 2^(AW-1);
  - the typedef for the signed audio word;
  - a `sat_clip` function (width-generic clip plus overflow flag).
- Sub-module `sd_mod1` contains the first-order modulator:
  - inputs `clk`, `rst_n`, `u[AW-1:0]`;
  - output `pdm_out`.
- The top level holds capture, the DC stage, gain/clip, hold, mute and the watchdog.

## Test plan
- **Reset idle:** release `rst_n` with no `d_valid` -> `underrun`=1; `pdm_out` alternates 0,1,0,1 (u=2048); `sat`=0.
- **Fixed offset, without `AUDIO_DC_BLOCK_EN`:** `d_in`=192, `gain`=0, one `d_valid` -> `s_hold`=64 at edge N+2; `pdm_out` has exactly 2112 ones in 4096 cycles.
- **Saturation:** `d_in`=255, `gain`=7 -> `sat` pulses once; `s_hold`=2047; `pdm_out` has 4095 ones per 4096 cycles. With `d_in`=0 -> `s_hold`=-2048 and `pdm_out` stuck at 0.
- **Mute:** stream `d_in`=255, `gain`=2, then raise `mute` -> density returns to 50% from the next cycle; `s_hold` keeps 508.
- **Underrun:** TIMEOUT=100, last `d_valid` at edge N -> `underrun` rises at edge N+100 and density goes to 50%; the next `d_valid` clears it one edge later.
- **DC block, with `AUDIO_DC_BLOCK_EN`:** 4096 consecutive valids of `d_in`=200, `gain`=0 -> first `s_hold`=72; `|s_hold|` ≤ 1 after the final sample.
